// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: streams two WIDTH-bit operands LSB-first through a 1-bit full-adder slice.
// Optional carry-in port enabled by defining SERIAL_ADD_CIN_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADD_CIN_EN
    input  logic             cin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] psum_hi;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [1:0]       slice_y;
    logic [WIDTH-1:0] psum_next;
    logic             start_carry;

    // Full-adder slice: {carry, sum} = a + b + c.
    always_comb begin
        slice_y   = {1'b0, a_sh[0]} + {1'b0, b_sh[0]} + {1'b0, carry};
        psum_next = {slice_y[0], psum_hi};
    end

`ifdef SERIAL_ADD_CIN_EN
    assign start_carry = cin;
`else
    assign start_carry = 1'b0;
`endif

    // Handshake: start is sampled only in IDLE; busy is high for the WIDTH
    // cycles of RUN; done pulses for one cycle with sum/cout already valid.
    // Requests seen in RUN or DONE are dropped, never queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            psum_hi <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        psum_hi <= '0;
                        carry   <= start_carry;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    psum_hi <= psum_next[WIDTH-1:1];
                    carry   <= slice_y[1];
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // Result registers load only here so sum never shows partial values.
                        sum   <= psum_next;
                        cout  <= slice_y[1];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed and random adds on WIDTH=8, exhaustive on WIDTH=3.
// Builds with or without SERIAL_ADD_CIN_EN.
module tb_serial_add_ctrl;
    localparam int W  = 8;
    localparam int W3 = 3;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         start   = 1'b0;
    logic         cin     = 1'b0;
    logic [W-1:0] a_in    = '0;
    logic [W-1:0] b_in    = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic          start3 = 1'b0;
    logic [W3-1:0] a3 = '0;
    logic [W3-1:0] b3 = '0;
    logic          busy3, done3, cout3;
    logic [W3-1:0] sum3;

    int total = 0;
    int bad   = 0;
    logic [W:0] exp_q[$];
    logic [W:0] last_exp = '0;

    // clock / reset
    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a_in(a_in), .b_in(b_in),
`ifdef SERIAL_ADD_CIN_EN
        .cin(cin),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(W3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .a_in(a3), .b_in(b3),
`ifdef SERIAL_ADD_CIN_EN
        .cin(cin),
`endif
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cin_eff(input logic c);
`ifdef SERIAL_ADD_CIN_EN
        return c;
`else
        return 1'b0;
`endif
    endfunction

    // reference model: plain integer addition, carry-out is bit W
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int unsigned s;
        s = int'(a) + int'(b) + (cin_eff(c) ? 1 : 0);
        return s[W:0];
    endfunction

    // scoreboard: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("sb_sum", 32'(sum), 32'(e[W-1:0]));
                chk("sb_cout", 32'(cout), 32'(e[W]));
            end
        end
    end

    // driver: one add, checks busy span, done latency and one-cycle done
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n;
        @(negedge clk);
        a_in = a; b_in = b; cin = c; start = 1'b1;
        last_exp = ref_add(a, b, c);
        exp_q.push_back(last_exp);
        @(negedge clk);
        start = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        n = 0;
        while (!done && n < 40) begin
            chk("busy_run", 32'(busy), 32'd1);
            n++;
            @(negedge clk);
        end
        chk("done_latency", 32'(n), 32'(W));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("sum_held", 32'(sum), 32'(last_exp[W-1:0]));
        chk("cout_held", 32'(cout), 32'(last_exp[W]));
    endtask

    initial begin
        int n;
        int seen;
        int last;

        // 1: reset with random inputs, then idle
        start = 1'b1; a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
        start3 = 1'b1; a3 = W3'($urandom); b3 = W3'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_sum3", 32'(sum3), 32'd0);
        start = 1'b0; start3 = 1'b0; reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_sum", 32'({cout, sum}), 32'd0);
        end

        // 2: A5 + 5A
        run_add(8'hA5, 8'h5A, 1'b0);
        chk("t2_sum", 32'(sum), 32'hFF);
        chk("t2_cout", 32'(cout), 32'd0);

        // 3: wrap-around cases
        run_add(8'hFF, 8'h01, 1'b0);
        chk("t3a_sum", 32'(sum), 32'h00);
        chk("t3a_cout", 32'(cout), 32'd1);
        run_add(8'h80, 8'h80, 1'b0);
        chk("t3b_sum", 32'(sum), 32'h00);
        chk("t3b_cout", 32'(cout), 32'd1);
        run_add(8'h00, 8'h00, 1'b0);
        chk("t3c_sum", 32'(sum), 32'h00);
        chk("t3c_cout", 32'(cout), 32'd0);

        // random adds
        repeat (20) run_add(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)));

        // 4: starts during RUN and DONE are ignored
        @(negedge clk);
        a_in = 8'd3; b_in = 8'd4; cin = 1'b0; start = 1'b1;
        last_exp = ref_add(8'd3, 8'd4, 1'b0);
        exp_q.push_back(last_exp);
        @(negedge clk);
        a_in = 8'h55; b_in = 8'h66; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t4_done_seen", 32'(done), 32'd1);
        a_in = 8'h11; b_in = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_busy_ignored", 32'(busy), 32'd0);
        repeat (20) begin
            chk("t4_no_second_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("t4_sum", 32'(sum), 32'h07);

        // 4b: start held high -> done every WIDTH+2 cycles
        a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start = 1'b1;
        last_exp = ref_add(8'h12, 8'h34, 1'b0);
        repeat (3) exp_q.push_back(last_exp);
        seen = 0; n = 0; last = 0;
        while (seen < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (done) begin
                if (seen > 0) chk("b2b_period", 32'(n - last), 32'(W + 2));
                last = n;
                seen++;
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(seen), 32'd3);
        repeat (12) @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'd0);

        // 5: reset in the middle of RUN aborts without a done pulse
        a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_sum", 32'(sum), 32'd0);
        chk("t5_cout", 32'(cout), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) begin
            chk("t5_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end

        // 6: carry-in
        run_add(8'hFF, 8'h00, 1'b1);
`ifdef SERIAL_ADD_CIN_EN
        chk("t6a_sum", 32'(sum), 32'h00);
        chk("t6a_cout", 32'(cout), 32'd1);
`else
        chk("t6a_sum", 32'(sum), 32'hFF);
        chk("t6a_cout", 32'(cout), 32'd0);
`endif
        run_add(8'h01, 8'h01, 1'b1);
`ifdef SERIAL_ADD_CIN_EN
        chk("t6b_sum", 32'(sum), 32'h03);
`else
        chk("t6b_sum", 32'(sum), 32'h02);
`endif

        // 7: exhaustive WIDTH=3
        cin = 1'b0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                a3 = W3'(a); b3 = W3'(b); start3 = 1'b1;
                @(negedge clk);
                start3 = 1'b0;
                n = 0;
                while (!done3 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("w3_done", 32'(done3), 32'd1);
                chk("w3_sum", 32'(sum3), 32'((a + b) % 8));
                chk("w3_cout", 32'(cout3), 32'((a + b) >= 8));
            end
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
